// File: rtl/tt3_bist_ctrl.sv
// tt3_bist_ctrl: clocked self-test sweep of the 3-input F/Fn gate block.
// Optional macro TT3_FNCHK_EN also fails a vector when Fn equals F.
module tt3_bist_ctrl #(
  parameter int unsigned HOLD_CYCLES = 4,
  parameter logic [7:0]  EXP_MASK    = 8'h3A
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       f_in,
  input  logic       fn_in,
  output logic       x,
  output logic       y,
  output logic       z,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] fail_vec,
  output logic [3:0] err_count
);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

  state_t     state_q;
  logic [2:0] idx_q;
  logic [7:0] hold_q;
  logic       busy_q;
  logic       done_q;
  logic       pass_q;
  logic [7:0] fail_vec_q;
  logic [3:0] err_count_q;

  logic       mism_d;
  logic       last_d;
  logic [7:0] fail_vec_d;
  logic [3:0] err_count_d;

`ifndef TT3_FNCHK_EN
  logic unused_fn;
  assign unused_fn = fn_in;
`endif

  // Per-sample verdict and the results as they stand after this sample
  always_comb begin
    mism_d = (f_in != EXP_MASK[idx_q]);
`ifdef TT3_FNCHK_EN
    mism_d = mism_d | (fn_in == f_in);
`endif
    last_d      = (hold_q == HOLD_LAST);
    fail_vec_d  = fail_vec_q;
    err_count_d = err_count_q;
    if (mism_d) begin
      fail_vec_d[idx_q] = 1'b1;
      err_count_d       = err_count_q + 4'd1;
    end
  end

  // Sweep sequencer with all outputs registered
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= 3'd0;
      hold_q      <= 8'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_vec_q  <= 8'h00;
      err_count_q <= 4'd0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_q     <= RUN;
            idx_q       <= 3'd0;
            hold_q      <= 8'd0;
            busy_q      <= 1'b1;
            pass_q      <= 1'b0;
            fail_vec_q  <= 8'h00;
            err_count_q <= 4'd0;
          end
        end
        RUN: begin
          if (!last_d) begin
            hold_q <= hold_q + 8'd1;
          end else begin
            hold_q      <= 8'd0;
            fail_vec_q  <= fail_vec_d;
            err_count_q <= err_count_d;
            if (idx_q == 3'd7) begin
              state_q <= IDLE;
              idx_q   <= 3'd0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              pass_q  <= (fail_vec_d == 8'h00);
            end else begin
              idx_q <= idx_q + 3'd1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign {x, y, z}  = idx_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign fail_vec   = fail_vec_q;
  assign err_count  = err_count_q;

endmodule

// File: tb/tb_tt3_bist_ctrl.sv
// tb_tt3_bist_ctrl: scoreboard bench for tt3_bist_ctrl.
// Two instances: hold of 4 cycles (a) and hold of 1 cycle (b).
module tb_tt3_bist_ctrl;

  typedef struct {
    logic [7:0]  fv;
    logic [3:0]  ec;
    logic        ps;
    int unsigned dc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic start_a, start_b;
  logic f_a, fn_a, f_b, fn_b;
  logic xa, ya, za, busy_a, done_a, pass_a;
  logic xb, yb, zb, busy_b, done_b, pass_b;
  logic [7:0] fv_a, fv_b;
  logic [3:0] ec_a, ec_b;
  int mode_a, mode_b;

  int unsigned cyc = 0;
  int nchk = 0;
  int nerr = 0;
  int bca = 0;
  int bcb = 0;
  exp_t qa[$];
  exp_t qb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  tt3_bist_ctrl #(.HOLD_CYCLES(4), .EXP_MASK(8'h3A)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a),
    .f_in(f_a), .fn_in(fn_a),
    .x(xa), .y(ya), .z(za),
    .busy(busy_a), .done(done_a), .pass(pass_a),
    .fail_vec(fv_a), .err_count(ec_a)
  );

  tt3_bist_ctrl #(.HOLD_CYCLES(1), .EXP_MASK(8'h3A)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b),
    .f_in(f_b), .fn_in(fn_b),
    .x(xb), .y(yb), .z(zb),
    .busy(busy_b), .done(done_b), .pass(pass_b),
    .fail_vec(fv_b), .err_count(ec_b)
  );

  // Gate block: F = x'z + xy'
  function automatic logic fblk(input logic [2:0] v);
    return (~v[2] & v[0]) | (v[2] & ~v[1]);
  endfunction

  // mode 0 good, 1 F stuck 0, 2 Fn tied to F, 3 F wrong on 2 and 5
  function automatic logic [1:0] blk(input int m, input logic [2:0] v);
    logic f;
    f = fblk(v);
    unique case (m)
      1: return 2'b01;
      2: return {f, f};
      3: begin
        f = f ^ ((v == 3'd2) || (v == 3'd5));
        return {f, ~f};
      end
      default: return {f, ~f};
    endcase
  endfunction

  always_comb {f_a, fn_a} = blk(mode_a, {xa, ya, za});
  always_comb {f_b, fn_b} = blk(mode_b, {xb, yb, zb});

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d at cyc %0d",
               n, act, exp, cyc);
    end
  endtask

  task automatic bad_done(input string n);
    nchk++;
    nerr++;
    $display("FAIL %s: done with nothing expected at cyc %0d", n, cyc);
  endtask

  // Monitor for instance a
  always @(negedge clk) begin
    exp_t e;
    if (busy_a) begin
      chk("xyz_a", {29'd0, xa, ya, za}, 32'(bca / 4));
      bca++;
    end else begin
      chk("idle_xyz_a", {29'd0, xa, ya, za}, 0);
      if (!done_a) bca = 0;
    end
    if (done_a) begin
      if (qa.size() == 0) bad_done("done_a");
      else begin
        e = qa.pop_front();
        chk("fv_a", 32'(fv_a), 32'(e.fv));
        chk("ec_a", 32'(ec_a), 32'(e.ec));
        chk("pass_a", 32'(pass_a), 32'(e.ps));
        chk("done_cyc_a", cyc, e.dc);
        chk("busy_len_a", bca, 32);
      end
      bca = 0;
    end
  end

  // Monitor for instance b
  always @(negedge clk) begin
    exp_t e;
    if (busy_b) begin
      chk("xyz_b", {29'd0, xb, yb, zb}, 32'(bcb));
      bcb++;
    end else begin
      chk("idle_xyz_b", {29'd0, xb, yb, zb}, 0);
      if (!done_b) bcb = 0;
    end
    if (done_b) begin
      if (qb.size() == 0) bad_done("done_b");
      else begin
        e = qb.pop_front();
        chk("fv_b", 32'(fv_b), 32'(e.fv));
        chk("ec_b", 32'(ec_b), 32'(e.ec));
        chk("pass_b", 32'(pass_b), 32'(e.ps));
        chk("done_cyc_b", cyc, e.dc);
        chk("busy_len_b", bcb, 8);
      end
      bcb = 0;
    end
  end

  task automatic push_a(input logic [7:0] fv, input logic [3:0] ec,
                        input logic ps, input int unsigned dc);
    exp_t e;
    e.fv = fv; e.ec = ec; e.ps = ps; e.dc = dc;
    qa.push_back(e);
  endtask

  task automatic push_b(input logic [7:0] fv, input logic [3:0] ec,
                        input logic ps, input int unsigned dc);
    exp_t e;
    e.fv = fv; e.ec = ec; e.ps = ps; e.dc = dc;
    qb.push_back(e);
  endtask

  task automatic run_a(input int m, input logic [7:0] fv,
                       input logic [3:0] ec, input logic ps);
    int unsigned t;
    @(negedge clk);
    mode_a  = m;
    start_a = 1'b1;
    t = cyc + 1;
    push_a(fv, ec, ps, t + 32);
    @(negedge clk);
    start_a = 1'b0;
    repeat (36) @(negedge clk);
  endtask

  task automatic chk_zero(input string n);
    chk({n, "_xyz"}, {29'd0, xa, ya, za}, 0);
    chk({n, "_busy"}, 32'(busy_a), 0);
    chk({n, "_done"}, 32'(done_a), 0);
    chk({n, "_pass"}, 32'(pass_a), 0);
    chk({n, "_fv"}, 32'(fv_a), 0);
    chk({n, "_ec"}, 32'(ec_a), 0);
  endtask

  initial begin
    int unsigned t;
    rst_n   = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    mode_a  = 0;
    mode_b  = 0;
    repeat (3) @(negedge clk);
    chk_zero("rst");
    chk("rst_b_busy", 32'(busy_b), 0);
    chk("rst_b_fv", 32'(fv_b), 0);
    rst_n = 1'b1;
    @(negedge clk);

    run_a(0, 8'h00, 4'd0, 1'b1);
    run_a(1, 8'h3A, 4'd4, 1'b0);
`ifdef TT3_FNCHK_EN
    run_a(2, 8'hFF, 4'd8, 1'b0);
`else
    run_a(2, 8'h00, 4'd0, 1'b1);
`endif
    run_a(3, 8'h24, 4'd2, 1'b0);

    // start pulsed again mid-sweep must be ignored
    @(negedge clk);
    mode_a  = 0;
    start_a = 1'b1;
    t = cyc + 1;
    push_a(8'h00, 4'd0, 1'b1, t + 32);
    @(negedge clk);
    start_a = 1'b0;
    repeat (4) @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (32) @(negedge clk);

    // reset while vector 3 is applied; no result expected
    @(negedge clk);
    mode_a  = 3;
    start_a = 1'b1;
    t = cyc + 1;
    @(negedge clk);
    start_a = 1'b0;
    while (cyc < t + 13) @(negedge clk);
    chk("pre_rst_vec", {29'd0, xa, ya, za}, 3);
    rst_n = 1'b0;
    @(negedge clk);
    chk_zero("midrst");
    rst_n = 1'b1;
    repeat (40) @(negedge clk);

    run_a(0, 8'h00, 4'd0, 1'b1);

    // hold of 1, start held through the first done cycle
    @(negedge clk);
    mode_b  = 0;
    start_b = 1'b1;
    t = cyc + 1;
    push_b(8'h00, 4'd0, 1'b1, t + 8);
    push_b(8'h00, 4'd0, 1'b1, t + 17);
    while (cyc < t + 9) @(negedge clk);
    start_b = 1'b0;
    repeat (12) @(negedge clk);

    @(negedge clk);
    mode_b  = 3;
    start_b = 1'b1;
    t = cyc + 1;
    push_b(8'h24, 4'd2, 1'b0, t + 8);
    @(negedge clk);
    start_b = 1'b0;
    repeat (12) @(negedge clk);

    for (int i = 0; i < 200 && (qa.size() != 0 || qb.size() != 0); i++)
      @(negedge clk);
    chk("qa_drained", qa.size(), 0);
    chk("qb_drained", qb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/tt3_bist_ctrl.md
# tt3_bist_ctrl

Built-in self-test sequencer for the three-input gate-level logic function block (inputs x, y, z; outputs F and Fn). When started, it drives all eight input combinations in ascending order and holds each for a programmable number of cycles. It compares the sampled F against an expected truth-table mask and optionally checks that Fn is the complement of F. It reports per-vector failures, an error count and a pass flag. It sits between the function block and the system controller, replacing the hand-written `$monitor` sweep with a synthesizable, clocked check.

## Interface
- HOLD_CYCLES, 4: cycles each vector is held before sampling; legal range 1..255.
- EXP_MASK, 8'h3A: expected F per vector; bit i = F for {x,y,z} = i (F = x'z + xy').
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  reset, synchronous and active-low.
- start  input  1  run request; sampled only in IDLE.
- f_in  input  1  F from the function block.
- fn_in  input  1  Fn from the function block.
- x, y, z  output  1 each  stimulus to the function block; {x,y,z} = vector index.
- busy  output  1  high while a sweep runs.
- done  output  1  one-cycle pulse when a sweep completes.
- pass  output  1  high when the last sweep had no failures; held until the next start.
- fail_vec  output  8  bit i set when vector i failed.
- err_count  output  4  number of failed vectors, 0..8.

## Operation
- States: IDLE, RUN.
- IDLE: {x,y,z} = 0, busy = 0. When start = 1 at a rising edge:
  - go to RUN;
  - set idx = 0 and hold_cnt = 0;
  - clear fail_vec, err_count and pass.
- RUN: {x,y,z} = idx and busy = 1. hold_cnt increments each cycle.
- When hold_cnt = HOLD_CYCLES-1, sample at that edge:
  - mismatch = (f_in != EXP_MASK[idx]);
  - if FNCHK_EN is defined, also mismatch when (fn_in == f_in);
  - on mismatch, set fail_vec[idx] and increment err_count;
  - reset hold_cnt to 0.
- After the sample, if idx < 7, increment idx and stay in RUN.
- After the sample with idx = 7:
  - go to IDLE;
  - drive {x,y,z} back to 0;
  - pulse done for one cycle;
  - set pass = (final fail_vec == 0).
- start is ignored while in RUN.
- Arithmetic:
  - idx is 3 bits.
  - hold_cnt is 8 bits.
  - err_count cannot exceed 8, so it needs no saturation.
- Outputs are registered. The function block is purely combinational, so x/y/z are stable for the whole hold window.

## Timing
- Reset values: x = y = z = 0, busy = 0, done = 0, pass = 0, fail_vec = 8'h00, err_count = 0. Internal state is IDLE, idx = 0, hold_cnt = 0.
- Start latency:
  - start is accepted at edge T;
  - vector 0 appears and busy = 1 from T+1.
- Each vector occupies exactly HOLD_CYCLES cycles. Its sample is taken at the edge ending its last cycle.
- Sweep latency:
  - busy is high for 8*HOLD_CYCLES cycles;
  - done = 1 during the first IDLE cycle, T + 8*HOLD_CYCLES + 1 relative to the accepting edge T;
  - pass, fail_vec and err_count are valid in the same cycle as done.
- HOLD_CYCLES = 1: every RUN cycle is a sample cycle, and the sweep lasts 8 cycles.
- Back-to-back runs:
  - start high in the done cycle is accepted, because the block is in IDLE;
  - done still pulses in that cycle;
  - results clear at that edge and a new sweep begins.
- Reset mid-run: rst_n = 0 at any edge forces every output to its reset value at that edge. No done pulse is produced, and the partial results are discarded.

## Configuration
- TT3_FNCHK_EN defined:
  - the complement check is active;
  - a vector fails if F mismatches EXP_MASK or if fn_in == f_in.
- TT3_FNCHK_EN undefined:
  - fn_in is ignored, and only F is compared;
  - the port is still present, to keep the interface identical.

## Test plan
- Function block connected, HOLD_CYCLES = 4, single start pulse:
  - busy is high for 32 cycles;
  - done pulses once;
  - pass = 1, fail_vec = 8'h00, err_count = 0;
  - x/y/z step 000..111, each held 4 cycles.
- f_in tied to 0, fn_in = 1, macro defined: fail_vec = 8'h3A, err_count = 4, pass = 0.
- fn_in tied to f_in with a correct F:
  - with TT3_FNCHK_EN: fail_vec = 8'hFF, err_count = 8;
  - without the macro: pass = 1, err_count = 0.
- Start re-asserted at cycle 5 of a sweep: ignored, and done still occurs at T + 33.
- rst_n = 0 while idx = 3, held 1 cycle, then a fresh start:
  - all outputs are zero after the reset edge, with no done;
  - the new sweep completes normally with pass = 1.
- HOLD_CYCLES = 1, start also held high in the done cycle:
  - two sweeps of 8 cycles each run back-to-back;
  - each produces its own done pulse with pass = 1.
